// File: rtl/string_buf_ctrl_pkg.sv
// Shared definitions for the line-editor controller: state encoding,
// key-event priority, blank character and default widths.
package string_buf_ctrl_pkg;

   localparam int unsigned AW_DEF = 4;
   localparam int unsigned CW_DEF = 8;

   localparam logic [7:0] BLANK_CHAR = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INS_SHIFT,
      ST_INS_WRITE,
      ST_DEL_SHIFT,
      ST_DEL_DONE,
      ST_EMIT
   } state_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_BS,
      EV_CHAR,
      EV_LEFT,
      EV_RIGHT,
      EV_DOWN
   } key_ev_t;

   // Highest-priority event wins; the rest are discarded without a drop.
   function automatic key_ev_t pick_event(input logic bs, input logic ch,
                                          input logic lf, input logic rt,
                                          input logic dn);
      if (bs)      return EV_BS;
      else if (ch) return EV_CHAR;
      else if (lf) return EV_LEFT;
      else if (rt) return EV_RIGHT;
      else if (dn) return EV_DOWN;
      else         return EV_NONE;
   endfunction

endpackage

// File: rtl/string_buf_ctrl_ram.sv
// Character buffer: DEPTH x CW register file, one synchronous write port,
// two asynchronous read ports (shift/emit path and display path).
module strbuf_ram
   import string_buf_ctrl_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [CW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [CW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [CW-1:0] rdata_b
);

   logic [CW-1:0] mem [2**AW];

   // Contents are deliberately not reset; validity is tracked by the length.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/string_buf_ctrl.sv
// Line-editor controller: key events edit a character buffer at a cursor,
// down streams the string out over valid/ready and clears it.
// Optional build macro STRBUF_CURSOR_WRAP_EN: left/right wrap the cursor
// at the ends instead of dropping the event.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | sample key events, left/right handled in place
// ST_INS_SHIFT | move entries up one slot per cycle from len down to cursor
// ST_INS_WRITE | write latched char at cursor, len+1, cursor+1
// ST_DEL_SHIFT | move entries down one slot per cycle from cursor-1 up
// ST_DEL_DONE  | len-1, cursor-1
// ST_EMIT      | present buf[rptr] on valid/ready until last handshake
module string_buf_ctrl
   import string_buf_ctrl_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          i_sclr_n,
   input  logic [CW-1:0] i_ascii,
   input  logic          i_char_en,
   input  logic          i_bs_en,
   input  logic          i_left_en,
   input  logic          i_right_en,
   input  logic          i_down_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [CW-1:0] o_rd_data,
   output logic [AW:0]   o_len,
   output logic [AW:0]   o_cursor,
   output logic          o_busy,
   output logic          o_drop,
   output logic [CW-1:0] o_out_data,
   output logic          o_out_valid,
   output logic          o_out_last,
   input  logic          i_out_ready
);

   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(2**AW);
   localparam logic [LW-1:0] ONE_L   = LW'(1);

   state_t        state_q;
   logic [LW-1:0] len_q, cur_q, idx_q;
   logic [AW-1:0] rptr_q;
   logic [LW-1:0] rptr_nx;
   logic [CW-1:0] char_q;
   logic          drop_q, out_valid_q, out_last_q;
   logic [CW-1:0] out_data_q;

   logic          ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [CW-1:0] ram_wdata, ram_rdata, disp_rdata;

   key_ev_t       ev;
   logic          any_ev;

   assign ev      = pick_event(i_bs_en, i_char_en, i_left_en, i_right_en, i_down_en);
   assign any_ev  = i_bs_en | i_char_en | i_left_en | i_right_en | i_down_en;
   assign rptr_nx = {1'b0, rptr_q} + ONE_L;

   strbuf_ram #(.AW(AW), .CW(CW)) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr_a (ram_raddr),
      .rdata_a (ram_rdata),
      .raddr_b (i_rd_addr),
      .rdata_b (disp_rdata)
   );

   // Buffer access: shift moves neighbour into idx; emit prefetches the next entry.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = idx_q[AW-1:0];
      ram_wdata = ram_rdata;
      ram_raddr = '0;
      case (state_q)
         ST_INS_SHIFT: begin
            ram_we    = 1'b1;
            ram_raddr = idx_q[AW-1:0] - AW'(1);
         end
         ST_INS_WRITE: begin
            ram_we    = 1'b1;
            ram_waddr = cur_q[AW-1:0];
            ram_wdata = char_q;
         end
         ST_DEL_SHIFT: begin
            ram_we    = 1'b1;
            ram_raddr = idx_q[AW-1:0] + AW'(1);
         end
         ST_EMIT:  ram_raddr = rptr_nx[AW-1:0];
         default:  ram_raddr = '0;
      endcase
   end

   // Editor FSM with counters and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!i_sclr_n) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cur_q       <= '0;
         idx_q       <= '0;
         rptr_q      <= '0;
         char_q      <= '0;
         drop_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         drop_q <= (state_q != ST_IDLE) && any_ev;
         case (state_q)
            ST_IDLE: begin
               case (ev)
                  EV_BS: begin
                     if (cur_q == '0) drop_q <= 1'b1;
                     else begin
                        idx_q   <= cur_q - ONE_L;
                        state_q <= (cur_q == len_q) ? ST_DEL_DONE : ST_DEL_SHIFT;
                     end
                  end
                  EV_CHAR: begin
                     if (len_q == DEPTH_L) drop_q <= 1'b1;
                     else begin
                        char_q  <= i_ascii;
                        idx_q   <= len_q;
                        state_q <= (len_q == cur_q) ? ST_INS_WRITE : ST_INS_SHIFT;
                     end
                  end
                  EV_LEFT: begin
                     if (cur_q != '0) cur_q <= cur_q - ONE_L;
                     else begin
`ifdef STRBUF_CURSOR_WRAP_EN
                        cur_q <= len_q;
`else
                        drop_q <= 1'b1;
`endif
                     end
                  end
                  EV_RIGHT: begin
                     if (cur_q != len_q) cur_q <= cur_q + ONE_L;
                     else begin
`ifdef STRBUF_CURSOR_WRAP_EN
                        cur_q <= '0;
`else
                        drop_q <= 1'b1;
`endif
                     end
                  end
                  EV_DOWN: begin
                     if (len_q == '0) drop_q <= 1'b1;
                     else begin
                        rptr_q      <= '0;
                        out_data_q  <= ram_rdata;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (len_q == ONE_L);
                        state_q     <= ST_EMIT;
                     end
                  end
                  default: ;
               endcase
            end
            ST_INS_SHIFT: begin
               idx_q <= idx_q - ONE_L;
               if ((idx_q - ONE_L) == cur_q) state_q <= ST_INS_WRITE;
            end
            ST_INS_WRITE: begin
               len_q   <= len_q + ONE_L;
               cur_q   <= cur_q + ONE_L;
               state_q <= ST_IDLE;
            end
            ST_DEL_SHIFT: begin
               idx_q <= idx_q + ONE_L;
               if ((idx_q + ONE_L) == (len_q - ONE_L)) state_q <= ST_DEL_DONE;
            end
            ST_DEL_DONE: begin
               len_q   <= len_q - ONE_L;
               cur_q   <= cur_q - ONE_L;
               state_q <= ST_IDLE;
            end
            ST_EMIT: begin
               if (i_out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     len_q       <= '0;
                     cur_q       <= '0;
                     state_q     <= ST_IDLE;
                  end else begin
                     rptr_q     <= rptr_nx[AW-1:0];
                     out_data_q <= ram_rdata;
                     out_last_q <= (rptr_nx == (len_q - ONE_L));
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_rd_data   = ({1'b0, i_rd_addr} >= len_q) ? CW'(BLANK_CHAR) : disp_rdata;
   assign o_len       = len_q;
   assign o_cursor    = cur_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_drop      = drop_q;
   assign o_out_data  = out_data_q;
   assign o_out_valid = out_valid_q;
   assign o_out_last  = out_last_q;

endmodule

// File: tb/tb_string_buf_ctrl.sv
// Bench for string_buf_ctrl: directed key sequences, scoreboard queues for
// completed operations and emitted characters, checked by a negedge monitor.
module tb_string_buf_ctrl;

   localparam int AW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          i_sclr_n;
   logic [CW-1:0] i_ascii;
   logic          i_char_en, i_bs_en, i_left_en, i_right_en, i_down_en;
   logic [AW-1:0] i_rd_addr;
   logic [CW-1:0] o_rd_data;
   logic [AW:0]   o_len, o_cursor;
   logic          o_busy, o_drop;
   logic [CW-1:0] o_out_data;
   logic          o_out_valid, o_out_last;
   logic          i_out_ready;

   string_buf_ctrl #(.AW(AW), .CW(CW)) dut (
      .clk         (clk),
      .i_sclr_n    (i_sclr_n),
      .i_ascii     (i_ascii),
      .i_char_en   (i_char_en),
      .i_bs_en     (i_bs_en),
      .i_left_en   (i_left_en),
      .i_right_en  (i_right_en),
      .i_down_en   (i_down_en),
      .i_rd_addr   (i_rd_addr),
      .o_rd_data   (o_rd_data),
      .o_len       (o_len),
      .o_cursor    (o_cursor),
      .o_busy      (o_busy),
      .o_drop      (o_drop),
      .o_out_data  (o_out_data),
      .o_out_valid (o_out_valid),
      .o_out_last  (o_out_last),
      .i_out_ready (i_out_ready)
   );

   always #5 clk = ~clk;

   typedef struct { int cycles; int len; int cur; } op_t;
   typedef struct { logic [7:0] data; logic last; } emit_t;

   op_t   op_q[$];
   emit_t emit_q[$];
   op_t   mon_op;
   emit_t mon_em;

   int   checks = 0;
   int   failures = 0;
   int   exp_drops = 0;
   int   seen_drops = 0;
   int   busy_run = 0;
   logic prev_busy = 1'b0;
   logic stall_prev = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: emitted characters, hold-while-stalled, drop pulses, completed ops.
   always @(negedge clk) begin
      if (o_drop === 1'b1) seen_drops++;
      if (stall_prev && o_out_valid === 1'b1) chk("out_hold", o_out_data, held);
      stall_prev = (o_out_valid === 1'b1) && (i_out_ready === 1'b0);
      held = o_out_data;
      if (o_out_valid === 1'b1 && i_out_ready === 1'b1) begin
         if (emit_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL emit_unexpected: got data %02h expected no output", o_out_data);
         end else begin
            mon_em = emit_q.pop_front();
            chk("emit_data", o_out_data, mon_em.data);
            chk("emit_last", o_out_last, mon_em.last);
         end
      end
      if (o_busy === 1'b1) busy_run++;
      else if (prev_busy) begin
         if (op_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL op_unexpected: busy ended after %0d cycles with no op expected", busy_run);
         end else begin
            mon_op = op_q.pop_front();
            chk("op_busy_cycles", busy_run, mon_op.cycles);
            chk("op_len", o_len, mon_op.len);
            chk("op_cursor", o_cursor, mon_op.cur);
         end
         busy_run = 0;
      end
      prev_busy = (o_busy === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k: 0 char, 1 backspace, 2 left, 3 right, 4 down
   task automatic key(input int k, input logic [7:0] ch);
      i_ascii    = ch;
      i_char_en  = (k == 0);
      i_bs_en    = (k == 1);
      i_left_en  = (k == 2);
      i_right_en = (k == 3);
      i_down_en  = (k == 4);
      tick();
      i_char_en = 0; i_bs_en = 0; i_left_en = 0; i_right_en = 0; i_down_en = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (o_busy !== 1'b0 && n < 64) begin
         tick();
         n++;
      end
      if (o_busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, o_busy, n);
      end
      tick();
   endtask

   task automatic push_op(input int cyc, input int len, input int cur);
      op_t o;
      o.cycles = cyc; o.len = len; o.cur = cur;
      op_q.push_back(o);
   endtask

   task automatic push_emit(input logic [7:0] d, input logic last);
      emit_t e;
      e.data = d; e.last = last;
      emit_q.push_back(e);
   endtask

   task automatic type_char(input logic [7:0] ch, input int cyc, input int len, input int cur);
      push_op(cyc, len, cur);
      key(0, ch);
      wait_idle("insert");
   endtask

   task automatic chk_str(input string name, input string s);
      for (int i = 0; i < s.len(); i++) begin
         i_rd_addr = AW'(i);
         #1;
         chk(name, o_rd_data, s[i]);
      end
      if (s.len() < 2**AW) begin
         i_rd_addr = AW'(s.len());
         #1;
         chk({name, "_blank"}, o_rd_data, 8'h20);
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_len"}, o_len, 0);
      chk({name, "_cursor"}, o_cursor, 0);
      chk({name, "_busy"}, o_busy, 0);
      chk({name, "_drop"}, o_drop, 0);
      chk({name, "_valid"}, o_out_valid, 0);
      chk({name, "_last"}, o_out_last, 0);
      chk({name, "_data"}, o_out_data, 0);
      i_rd_addr = '0;
      #1;
      chk({name, "_rd_blank"}, o_rd_data, 8'h20);
   endtask

   initial begin
      i_sclr_n = 0; i_ascii = 0; i_char_en = 0; i_bs_en = 0; i_left_en = 0;
      i_right_en = 0; i_down_en = 0; i_rd_addr = 0; i_out_ready = 0;
      repeat (3) tick();
      chk_reset_state("reset");
      i_sclr_n = 1;
      tick();

      // Append three characters
      type_char(8'h41, 1, 1, 1);
      tick();
      type_char(8'h42, 1, 2, 2);
      tick();
      type_char(8'h43, 1, 3, 3);
      chk("abc_len", o_len, 3);
      chk("abc_cursor", o_cursor, 3);
      chk_str("abc_buf", "ABC");

      // Insert mid-string
      key(2, 0);
      chk("left1_cursor", o_cursor, 2);
      key(2, 0);
      chk("left2_cursor", o_cursor, 1);
      type_char(8'h58, 3, 4, 2);
      chk_str("axbc_buf", "AXBC");

      // Backspace twice, then once more at cursor 0
      push_op(3, 3, 1);
      key(1, 0);
      wait_idle("bs1");
      chk_str("bs1_buf", "ABC");
      push_op(3, 2, 0);
      key(1, 0);
      wait_idle("bs2");
      chk_str("bs2_buf", "BC");
      key(1, 0);
      exp_drops++;
      chk("bs_drop_pulse", o_drop, 1);
      tick();
      chk("bs_drop_clear", o_drop, 0);
      chk("bs_drop_len", o_len, 2);
      chk("drops_after_bs", seen_drops, exp_drops);

      // Emit "BC" with ready held high
      push_emit(8'h42, 0);
      push_emit(8'h43, 1);
      push_op(2, 0, 0);
      i_out_ready = 1;
      key(4, 0);
      wait_idle("emit_bc");
      i_out_ready = 0;
      chk("emit_bc_len", o_len, 0);

      // Fill to capacity, then overflow and right at the end
      for (int i = 0; i < 16; i++) type_char(8'h61 + 8'(i), 1, i + 1, i + 1);
      chk("full_len", o_len, 16);
      chk_str("full_buf", "abcdefghijklmnop");
      key(0, 8'h5a);
      exp_drops++;
      tick();
      chk("overflow_len", o_len, 16);
      chk("drops_after_overflow", seen_drops, exp_drops);
      key(3, 0);
`ifdef STRBUF_CURSOR_WRAP_EN
      chk("right_wrap_cursor", o_cursor, 0);
`else
      exp_drops++;
      chk("right_end_cursor", o_cursor, 16);
`endif
      tick();
      chk("drops_after_right", seen_drops, exp_drops);

      for (int i = 0; i < 16; i++) push_emit(8'h61 + 8'(i), i == 15);
      push_op(16, 0, 0);
      i_out_ready = 1;
      key(4, 0);
      wait_idle("emit_full");
      i_out_ready = 0;

      // Emit "ABC" with ready pattern 1,0,1,1
      type_char(8'h41, 1, 1, 1);
      type_char(8'h42, 1, 2, 2);
      type_char(8'h43, 1, 3, 3);
      push_emit(8'h41, 0);
      push_emit(8'h42, 0);
      push_emit(8'h43, 1);
      push_op(4, 0, 0);
      key(4, 0);
      i_out_ready = 1; tick();
      i_out_ready = 0; tick();
      i_out_ready = 1; tick();
      i_out_ready = 1; tick();
      i_out_ready = 0;
      wait_idle("emit_abc");
      chk("emit_abc_len", o_len, 0);
      chk("emit_abc_cursor", o_cursor, 0);

      // Event while shifting, then reset mid-emit
      type_char(8'h41, 1, 1, 1);
      type_char(8'h42, 1, 2, 2);
      type_char(8'h43, 1, 3, 3);
      for (int i = 0; i < 3; i++) key(2, 0);
      chk("left3_cursor", o_cursor, 0);
      push_op(4, 4, 1);
      key(0, 8'h51);
      i_ascii = 8'h52;
      i_char_en = 1;
      tick();
      i_char_en = 0;
      exp_drops++;
      chk("busy_drop_pulse", o_drop, 1);
      wait_idle("ins_q");
      chk_str("qabc_buf", "QABC");
      chk("drops_after_busy", seen_drops, exp_drops);
      push_op(3, 0, 0);
      key(4, 0);
      chk("emit_q_valid", o_out_valid, 1);
      chk("emit_q_data", o_out_data, 8'h51);
      tick();
      tick();
      i_sclr_n = 0;
      tick();
      chk_reset_state("midemit_reset");
      i_sclr_n = 1;
      repeat (3) tick();

      chk("ops_pending", op_q.size(), 0);
      chk("emits_pending", emit_q.size(), 0);
      chk("drops_final", seen_drops, exp_drops);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
